// File: rtl/morra_match_driver.sv
// ---------------------------------------------------------------------------
// morra_match_driver
//
// Initiator side of the morra referee interface. Opens a match with a one
// cycle INIZIO strobe carrying the match length code, then presents one move
// pair per cycle on PRIMO/SECONDO and watches MANCHE/PARTITA. An internal
// predictor computes the expected MANCHE of every pair and flags any
// disagreement. Intended as on-chip stimulus / self-test for the referee.
//
// Parameters
//   SEED_P1, SEED_P2  initial LFSR state of each player (must be nonzero)
//   RISP_LAT          cycles from a pair on PRIMO/SECONDO to its MANCHE (1..4)
//
// Ports
//   clk         clock, all state on posedge
//   rst         asynchronous active-high reset, aborts any match
//   start       begin a match (only looked at while idle)
//   n_cfg[3:0]  match length code, length = n_cfg + 4
//   MANCHE[1:0] per-round result from the referee
//   PARTITA[1:0] match result from the referee, 00 while running
//   INIZIO      setup strobe
//   PRIMO[1:0]  player 1 move, n_cfg[1:0] during setup
//   SECONDO[1:0] player 2 move, n_cfg[3:2] during setup
//   busy        high from setup through the final cycle
//   done        one-cycle pulse at match end
//   risultato   latched final PARTITA, 00 on timeout
//   turni       move pairs presented in this match (saturates at 19)
//   errore      referee timeout, sticky until next start
//   disaccordo  MANCHE differed from prediction, sticky until next start
//
// Build option
//   MORRA_DRIVER_FORCED_MOVES_EN adds forza / mossa_p1 / mossa_p2 so the moves
//   can be supplied from outside instead of from the LFSRs.
// ---------------------------------------------------------------------------
module morra_match_driver #(
   parameter logic [15:0] SEED_P1  = 16'hACE1,
   parameter logic [15:0] SEED_P2  = 16'h1D2B,
   parameter int unsigned RISP_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] n_cfg,
   input  logic [1:0] MANCHE,
   input  logic [1:0] PARTITA,
`ifdef MORRA_DRIVER_FORCED_MOVES_EN
   input  logic       forza,
   input  logic [1:0] mossa_p1,
   input  logic [1:0] mossa_p2,
`endif
   output logic       INIZIO,
   output logic [1:0] PRIMO,
   output logic [1:0] SECONDO,
   output logic       busy,
   output logic       done,
   output logic [1:0] risultato,
   output logic [4:0] turni,
   output logic       errore,
   output logic       disaccordo
);

   // state | meaning
   // IDLE  | waiting for start, results of the last match held
   // SETUP | INIZIO strobe with the length code on the move lines
   // PLAY  | one new move pair per cycle until the match length is reached
   // DRAIN | moves 00, waiting RISP_LAT+1 cycles for PARTITA
   // FINE  | done pulse, then back to IDLE
   typedef enum logic [2:0] {IDLE, SETUP, PLAY, DRAIN, FINE} state_t;

   // Stage 0 holds the prediction of the pair currently on the outputs; the
   // entry reaches the last stage in the cycle its MANCHE is due.
   localparam int unsigned DEPTH = RISP_LAT + 1;

   state_t           state;
   logic [3:0]       n_lat;
   logic [4:0]       n_len;
   logic [15:0]      lfsr_p1;
   logic [15:0]      lfsr_p2;
   logic [1:0]       win_who;    // 01 player 1, 10 player 2, 00 none
   logic [1:0]       win_move;
   logic [2:0]       drain_cnt;
   logic [1:0]       pipe_res [DEPTH];
   logic [DEPTH-1:0] pipe_vld;

   logic             present_now;
   logic             step_lfsr;
   logic             pred_vld;
   logic [1:0]       raw1;
   logic [1:0]       raw2;
   logic [1:0]       mv1;
   logic [1:0]       mv2;
   logic [1:0]       pred;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic logic [1:0] lfsr_move(input logic [15:0] s);
      return (s[1:0] == 2'b00) ? 2'b01 : s[1:0];
   endfunction

   function automatic logic [1:0] rotate(input logic [1:0] m);
      logic [1:0] r;
      case (m)
         2'b01:   r = 2'b10;
         2'b10:   r = 2'b11;
         2'b11:   r = 2'b01;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   // Round outcome in MANCHE encoding; any 00 move makes the round invalid.
   function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
      if (a == 2'b00 || b == 2'b00) return 2'b00;
      if (a == b) return 2'b11;
      if ((a == 2'b10 && b == 2'b01) || (a == 2'b11 && b == 2'b10) ||
          (a == 2'b01 && b == 2'b11)) return 2'b01;
      return 2'b10;
   endfunction

   assign n_len = {1'b0, n_lat} + 5'd4;

   // A pair is produced on the SETUP->PLAY edge and on every PLAY edge until
   // the length is reached, unless the referee has just ended the match.
   assign present_now = (state == SETUP) ||
                        (state == PLAY && PARTITA == 2'b00 && turni < n_len);

   always_comb begin
      raw1      = lfsr_move(lfsr_p1);
      raw2      = lfsr_move(lfsr_p2);
      mv1       = raw1;
      mv2       = raw2;
      // The last round winner may not repeat its winning move.
      if (win_who == 2'b01 && raw1 == win_move) mv1 = rotate(raw1);
      if (win_who == 2'b10 && raw2 == win_move) mv2 = rotate(raw2);
      pred      = judge(mv1, mv2);
      step_lfsr = 1'b1;
`ifdef MORRA_DRIVER_FORCED_MOVES_EN
      if (forza) begin
         mv1       = mossa_p1;
         mv2       = mossa_p2;
         step_lfsr = 1'b0;
         // A forced repeat of the winning move is an illegal round.
         if ((win_who == 2'b01 && mossa_p1 == win_move) ||
             (win_who == 2'b10 && mossa_p2 == win_move))
            pred = 2'b00;
         else
            pred = judge(mossa_p1, mossa_p2);
      end
`endif
      pred_vld  = (mv1 != 2'b00) && (mv2 != 2'b00);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         n_lat      <= 4'd0;
         lfsr_p1    <= SEED_P1;
         lfsr_p2    <= SEED_P2;
         win_who    <= 2'b00;
         win_move   <= 2'b00;
         drain_cnt  <= 3'd0;
         pipe_vld   <= '0;
         for (int i = 0; i < DEPTH; i++) pipe_res[i] <= 2'b00;
         INIZIO     <= 1'b0;
         PRIMO      <= 2'b00;
         SECONDO    <= 2'b00;
         busy       <= 1'b0;
         done       <= 1'b0;
         risultato  <= 2'b00;
         turni      <= 5'd0;
         errore     <= 1'b0;
         disaccordo <= 1'b0;
      end else begin
         done <= 1'b0;

         pipe_vld <= {pipe_vld[DEPTH-2:0], 1'b0};
         for (int i = 1; i < DEPTH; i++) pipe_res[i] <= pipe_res[i-1];

         if (pipe_vld[DEPTH-1] && MANCHE != pipe_res[DEPTH-1])
            disaccordo <= 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SETUP;
                  n_lat      <= n_cfg;
                  INIZIO     <= 1'b1;
                  PRIMO      <= n_cfg[1:0];
                  SECONDO    <= n_cfg[3:2];
                  busy       <= 1'b1;
                  turni      <= 5'd0;
                  errore     <= 1'b0;
                  disaccordo <= 1'b0;
                  risultato  <= 2'b00;
                  win_who    <= 2'b00;
                  win_move   <= 2'b00;
               end
            end
            SETUP: begin
               INIZIO <= 1'b0;
               state  <= PLAY;
            end
            PLAY: begin
               if (PARTITA != 2'b00) begin
                  state     <= FINE;
                  done      <= 1'b1;
                  risultato <= PARTITA;
                  PRIMO     <= 2'b00;
                  SECONDO   <= 2'b00;
                  pipe_vld  <= '0;
               end else if (turni >= n_len) begin
                  state     <= DRAIN;
                  PRIMO     <= 2'b00;
                  SECONDO   <= 2'b00;
                  drain_cnt <= 3'(RISP_LAT);
               end
            end
            DRAIN: begin
               // PARTITA takes priority over an expiring drain count.
               if (PARTITA != 2'b00) begin
                  state     <= FINE;
                  done      <= 1'b1;
                  risultato <= PARTITA;
                  pipe_vld  <= '0;
               end else if (drain_cnt == 3'd0) begin
                  state     <= FINE;
                  done      <= 1'b1;
                  risultato <= 2'b00;
                  errore    <= 1'b1;
                  pipe_vld  <= '0;
               end else begin
                  drain_cnt <= drain_cnt - 3'd1;
               end
            end
            FINE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               INIZIO   <= 1'b0;
               PRIMO    <= 2'b00;
               SECONDO  <= 2'b00;
               busy     <= 1'b0;
               pipe_vld <= '0;
            end
         endcase

         if (present_now) begin
            PRIMO       <= mv1;
            SECONDO     <= mv2;
            pipe_vld[0] <= pred_vld;
            pipe_res[0] <= pred;
            if (turni != 5'd19) turni <= turni + 5'd1;
            if (step_lfsr) begin
               lfsr_p1 <= lfsr_next(lfsr_p1);
               lfsr_p2 <= lfsr_next(lfsr_p2);
            end
            case (pred)
               2'b01: begin
                  win_who  <= 2'b01;
                  win_move <= mv1;
               end
               2'b10: begin
                  win_who  <= 2'b10;
                  win_move <= mv2;
               end
               default: begin
                  win_who  <= 2'b00;
                  win_move <= 2'b00;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_morra_match_driver.sv
module tb_morra_match_driver;

   localparam logic [15:0] SEED1 = 16'hACE1;
   localparam logic [15:0] SEED2 = 16'h1D2B;
   localparam int LAT = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] n_cfg;
   logic [1:0] MANCHE;
   logic [1:0] PARTITA;
   logic       INIZIO;
   logic [1:0] PRIMO;
   logic [1:0] SECONDO;
   logic       busy;
   logic       done;
   logic [1:0] risultato;
   logic [4:0] turni;
   logic       errore;
   logic       disaccordo;
`ifdef MORRA_DRIVER_FORCED_MOVES_EN
   logic       forza;
   logic [1:0] mossa_p1;
   logic [1:0] mossa_p2;
`endif

   int total;
   int bad;

   always #5 clk = ~clk;

   morra_match_driver #(.SEED_P1(SEED1), .SEED_P2(SEED2), .RISP_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .n_cfg(n_cfg),
      .MANCHE(MANCHE), .PARTITA(PARTITA),
`ifdef MORRA_DRIVER_FORCED_MOVES_EN
      .forza(forza), .mossa_p1(mossa_p1), .mossa_p2(mossa_p2),
`endif
      .INIZIO(INIZIO), .PRIMO(PRIMO), .SECONDO(SECONDO), .busy(busy),
      .done(done), .risultato(risultato), .turni(turni),
      .errore(errore), .disaccordo(disaccordo)
   );

   typedef struct {
      logic [3:0] n;
      int         er;    // round whose MANCHE carries PARTITA (0 = never)
      int         pd;    // extra cycles before PARTITA after that MANCHE
      logic [1:0] ev;
      int         cor;   // round whose MANCHE is corrupted (0 = none)
      logic [1:0] ris;
      logic       err;
      logic       dis;
      logic [4:0] tur;
   } vec_t;

   typedef struct {
      logic [1:0]  p1;
      logic [1:0]  p2;
      logic [15:0] l1;
      logic [15:0] l2;
   } pair_t;

   typedef struct {
      logic [1:0] res;
      int         rnd;
   } ref_t;

   vec_t  vtab [7];
   pair_t exp_q [$];
   ref_t  ref_q [$];
   logic [15:0] m_l1;
   logic [15:0] m_l2;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [1:0] ideal(input logic [1:0] a, input logic [1:0] b);
      if (a == 2'b00 || b == 2'b00) return 2'b00;
      if (a == b) return 2'b11;
      return (a == b % 2'd3 + 2'd1) ? 2'b01 : 2'b10;
   endfunction

   // Expected pairs for a whole match, with the LFSR state after each one.
   task automatic gen_pairs(input int n);
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  who;
      logic [1:0]  wm;
      logic [1:0]  r1;
      logic [1:0]  r2;
      logic [1:0]  o;
      a = m_l1; b = m_l2; who = 2'b00; wm = 2'b00;
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         r1 = (a[1:0] == 2'b00) ? 2'b01 : a[1:0];
         r2 = (b[1:0] == 2'b00) ? 2'b01 : b[1:0];
         if (who == 2'b01 && r1 == wm) r1 = r1 % 2'd3 + 2'd1;
         if (who == 2'b10 && r2 == wm) r2 = r2 % 2'd3 + 2'd1;
         o   = ideal(r1, r2);
         who = (o == 2'b01 || o == 2'b10) ? o : 2'b00;
         wm  = (o == 2'b01) ? r1 : (o == 2'b10) ? r2 : 2'b00;
         a   = {a[14:0], ^(a & 16'hB400)};
         b   = {b[14:0], ^(b & 16'hB400)};
         exp_q.push_back('{r1, r2, a, b});
      end
   endtask

   task automatic run_vec(input vec_t v, input bit keep);
      int    rnd;
      int    pcnt;
      int    drn;
      bit    fin;
      ref_t  e;
      pair_t p;
      logic [1:0] r;
      gen_pairs(int'(v.n) + 4);
      ref_q.delete();
      @(negedge clk);
      n_cfg = v.n;
      start = 1'b1;
      @(negedge clk);
      chk("setup_inizio", INIZIO, 1);
      chk("setup_cfg", {SECONDO, PRIMO}, v.n);
      if (!keep) start = 1'b0;
      n_cfg = ~v.n;
      rnd = 0; pcnt = -1; drn = 0; fin = 1'b0;
      for (int c = 0; c < 120 && !fin; c++) begin
         @(negedge clk);
         if (done) begin
            fin = 1'b1;
            MANCHE = 2'b00;
            PARTITA = 2'b00;
         end else begin
            if (busy && (PRIMO != 2'b00 || SECONDO != 2'b00)) begin
               rnd++;
               if (exp_q.size() == 0) begin
                  chk("extra_pair", rnd, 0);
               end else begin
                  p = exp_q.pop_front();
                  chk("move_p1", PRIMO, p.p1);
                  chk("move_p2", SECONDO, p.p2);
                  m_l1 = p.l1;
                  m_l2 = p.l2;
               end
               r = ideal(PRIMO, SECONDO);
               if (rnd == v.cor) r = (r == 2'b01) ? 2'b10 : 2'b01;
               ref_q.push_back('{r, rnd});
            end else begin
               drn++;
               ref_q.push_back('{2'b00, 0});
            end
            if (ref_q.size() > LAT) begin
               e = ref_q.pop_front();
               MANCHE = e.res;
               if (v.er != 0 && e.rnd == v.er) pcnt = v.pd;
            end else begin
               MANCHE = 2'b00;
            end
            PARTITA = (pcnt == 0) ? v.ev : 2'b00;
            if (pcnt >= 0) pcnt--;
         end
      end
      if (!fin) begin
         chk("match_timeout", done, 1);
      end else begin
         chk("risultato", risultato, v.ris);
         chk("errore", errore, v.err);
         chk("disaccordo", disaccordo, v.dis);
         chk("turni", turni, v.tur);
         chk("busy_fine", busy, 1);
         if (v.err) chk("drain_len", drn, LAT + 1);
         @(negedge clk);
         chk("done_pulse", done, 0);
         chk("busy_idle", busy, 0);
         chk("disaccordo_hold", disaccordo, v.dis);
         if (keep) chk("no_restart_yet", INIZIO, 0);
      end
   endtask

`ifdef MORRA_DRIVER_FORCED_MOVES_EN
   task automatic run_forced();
      logic [1:0] f1 [4];
      logic [1:0] f2 [4];
      logic [1:0] fr [4];
      int   k;
      bit   fin;
      ref_t e;
      f1 = '{2'b10, 2'b10, 2'b01, 2'b00};
      f2 = '{2'b01, 2'b11, 2'b01, 2'b10};
      fr = '{2'b01, 2'b00, 2'b11, 2'b10};
      ref_q.delete();
      forza = 1'b1; mossa_p1 = f1[0]; mossa_p2 = f2[0];
      @(negedge clk);
      n_cfg = 4'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0; fin = 1'b0;
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clk);
         if (done) begin
            fin = 1'b1;
            MANCHE = 2'b00;
            chk("forced_disaccordo", disaccordo, 0);
            chk("forced_errore", errore, 1);
            chk("forced_turni", turni, 4);
         end else begin
            if (busy && k < 4 && (PRIMO != 2'b00 || SECONDO != 2'b00)) begin
               chk("forced_p1", PRIMO, f1[k]);
               chk("forced_p2", SECONDO, f2[k]);
               ref_q.push_back('{fr[k], k + 1});
               k++;
               if (k < 4) begin
                  mossa_p1 = f1[k];
                  mossa_p2 = f2[k];
               end
            end else begin
               ref_q.push_back('{2'b00, 0});
            end
            if (ref_q.size() > LAT) begin
               e = ref_q.pop_front();
               MANCHE = e.res;
            end else begin
               MANCHE = 2'b00;
            end
         end
      end
      if (!fin) chk("forced_timeout", done, 1);
      forza = 1'b0;
      @(negedge clk);
   endtask
`endif

   initial begin
      logic [3:0] nx;
      total = 0; bad = 0;
      rst = 1'b1; start = 1'b0; n_cfg = 4'd0; MANCHE = 2'b00; PARTITA = 2'b00;
`ifdef MORRA_DRIVER_FORCED_MOVES_EN
      forza = 1'b0; mossa_p1 = 2'b00; mossa_p2 = 2'b00;
`endif
      m_l1 = SEED1; m_l2 = SEED2;
      //          n     er  pd  ev     cor ris    err   dis   turni
      vtab[0] = '{4'd0,  4, 0, 2'b01, 0, 2'b01, 1'b0, 1'b0, 5'd4};
      vtab[1] = '{4'd4,  0, 0, 2'b00, 0, 2'b00, 1'b1, 1'b0, 5'd8};
      vtab[2] = '{4'd2,  3, 0, 2'b10, 2, 2'b10, 1'b0, 1'b1, 5'd4};
      vtab[3] = '{4'd5,  0, 0, 2'b00, 0, 2'b00, 1'b1, 1'b0, 5'd9};
      vtab[4] = '{4'd15, 19, 0, 2'b11, 0, 2'b11, 1'b0, 1'b0, 5'd19};
      vtab[5] = '{4'd0,  4, 1, 2'b10, 0, 2'b10, 1'b0, 1'b0, 5'd4};
      vtab[6] = '{4'd1,  2, 0, 2'b01, 0, 2'b01, 1'b0, 1'b0, 5'd3};

      repeat (3) @(negedge clk);
      chk("rst_inizio", INIZIO, 0);
      chk("rst_moves", {SECONDO, PRIMO}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_risultato", risultato, 0);
      chk("rst_turni", turni, 0);
      chk("rst_errore", errore, 0);
      chk("rst_disaccordo", disaccordo, 0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(vtab[i], 1'b0);

      // start held through the end: one IDLE cycle, then a fresh SETUP
      run_vec(vtab[6], 1'b1);
      nx = ~vtab[6].n;
      @(negedge clk);
      chk("resetup_inizio", INIZIO, 1);
      chk("resetup_cfg", {SECONDO, PRIMO}, nx);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", busy, 1);

      // reset in the middle of PLAY
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_inizio", INIZIO, 0);
      chk("midrst_moves", {SECONDO, PRIMO}, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_turni", turni, 0);
      @(negedge clk);
      rst = 1'b0;
      m_l1 = SEED1; m_l2 = SEED2;
      run_vec(vtab[0], 1'b0);

`ifdef MORRA_DRIVER_FORCED_MOVES_EN
      run_forced();
      run_vec(vtab[6], 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
